clkgen_sched: RTL



---
 rtl/clkgen_pkg.sv | 31 +++
 rtl/clkgen_cfg_regs.sv | 67 ++++++
 rtl/clkgen_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg
// Shared types for the programmable clock generator: the FSM state
// encoding, the configuration record and its legality check.
package clkgen_pkg;

  // Width of the period / high-time / phase fields carried in cfg_t.
  localparam int CFG_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PHASE = 2'd1;
  localparam state_t ST_HIGH  = 2'd2;
  localparam state_t ST_LOW   = 2'd3;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } cfg_t;

  // A waveform needs at least one high and one low cycle per period, and
  // the start delay must be shorter than one period.
  function automatic bit cfg_legal(cfg_t c);
    return (c.period >= CFG_W'(2)) &&
           (c.high   >= CFG_W'(1)) &&
           (c.high   <  c.period)  &&
           (c.phase  <  c.period);
  endfunction

endpackage

// File: rtl/clkgen_cfg_regs.sv
// clkgen_cfg_regs
// Configuration side of the clock generator: valid/ready handshake,
// legality check, active registers and a one-deep shadow for updates
// offered while the generator is running.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   cfg_valid     configuration offer
//   cfg_in        offered configuration
//   busy          generator is outside IDLE (updates go to the shadow)
//   apply         copy shadow into the active registers this cycle
//   cfg_ready     offer can be accepted (no shadow waiting)
//   cfg_err       one-cycle pulse after an illegal offer was accepted
//   cfg_loaded    active registers hold a legal configuration
//   pending       shadow holds a configuration not yet applied
//   cfg_act       active configuration
//   cfg_shadow    shadow configuration
module clkgen_cfg_regs
  import clkgen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_valid,
  input  cfg_t cfg_in,
  input  logic busy,
  input  logic apply,
  output logic cfg_ready,
  output logic cfg_err,
  output logic cfg_loaded,
  output logic pending,
  output cfg_t cfg_act,
  output cfg_t cfg_shadow
);

  logic accept;
  logic legal;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = cfg_legal(cfg_in);

  // apply only happens with pending set, and accept only with pending
  // clear, so the two branches below never compete in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err    <= 1'b0;
      cfg_loaded <= 1'b0;
      pending    <= 1'b0;
      cfg_act    <= '0;
      cfg_shadow <= '0;
    end else begin
      cfg_err <= accept && !legal;
      if (apply) begin
        cfg_act <= cfg_shadow;
        pending <= 1'b0;
      end else if (accept && legal) begin
        if (busy) begin
          cfg_shadow <= cfg_in;
          pending    <= 1'b1;
        end else begin
          cfg_act    <= cfg_in;
          cfg_loaded <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clkgen_sched.sv
// clkgen_sched
// Programmable divided-clock generator. After an optional start delay
// (phase) it produces a waveform that is high for 'high' cycles out of
// every 'period' cycles of clk. Configuration changes made while running
// take effect at the next period boundary or on sync.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   cfg_valid/cfg_ready   configuration handshake
//   cfg_period/high/phase configuration fields (clk cycles)
//   cfg_err               one-cycle pulse: offered configuration rejected
//   en                    run request
//   sync                  one-cycle restart request
//   clk_out               generated waveform (registered)
//   rise_pulse/fall_pulse first cycle of clk_out high / low
//   running               generator active (registered alongside clk_out)
module clkgen_sched
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CFG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  input  logic             en,
  input  logic             sync,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             running
);

  state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  cfg_t       cfg_in, cfg_act, cfg_shadow, cfg_use;
  logic       cfg_loaded, pending;
  logic       busy, last, boundary, apply, start;

  assign cfg_in   = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
  assign busy     = (state != ST_IDLE);
  assign last     = (cnt == CNT_W'(1));
  assign boundary = (state == ST_LOW) && last;

  // A waiting shadow is applied at a period boundary, on sync, or at once
  // if the generator has already dropped back to IDLE (PHASE abort).
  assign apply   = pending && (!busy || sync || boundary);
  assign cfg_use = apply ? cfg_shadow : cfg_act;

  clkgen_cfg_regs u_cfg_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_in     (cfg_in),
    .busy       (busy),
    .apply      (apply),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cfg_loaded (cfg_loaded),
    .pending    (pending),
    .cfg_act    (cfg_act),
    .cfg_shadow (cfg_shadow)
  );

  // cnt holds the cycles remaining in the current state; states advance
  // when it reaches 1. A start (from IDLE or via sync) loads from cfg_use
  // so that a shadow applied in the same cycle is already in effect.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && cfg_loaded && !(cfg_valid && cfg_ready)) start = 1'b1;
      end
      ST_PHASE: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else if (sync) begin
          start = 1'b1;
        end else if (last) begin
          state_nx = ST_HIGH;
          cnt_nx   = cfg_use.high;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (sync) begin
          start = 1'b1;
        end else if (last) begin
          state_nx = ST_LOW;
          cnt_nx   = cfg_use.period - cfg_use.high;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (sync) begin
          start = 1'b1;
        end else if (last) begin
          if (en) begin
            state_nx = ST_HIGH;
            cnt_nx   = cfg_use.high;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (start) begin
      if (cfg_use.phase == '0) begin
        state_nx = ST_HIGH;
        cnt_nx   = cfg_use.high;
      end else begin
        state_nx = ST_PHASE;
        cnt_nx   = cfg_use.phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are registered one cycle behind the state, which gives the
  // extra start cycle between en being sampled and the waveform beginning.
  // Edge pulses compare against the previous clk_out so a sync that keeps
  // the output high produces no rise, and an early fall still pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      running    <= 1'b0;
    end else begin
      clk_out    <= (state == ST_HIGH);
      rise_pulse <= (state == ST_HIGH) && !clk_out;
      fall_pulse <= (state != ST_HIGH) && clk_out;
      running    <= busy;
    end
  end

endmodule
